// File: rtl/mcm_collect.sv
// Frame collector: hunts for a two-byte sync marker, then streams FRAME_LEN payload
// bytes into the MCM RAM write port, with inter-byte timeout supervision.
module mcm_collect #(
  parameter int          FRAME_LEN = 144,
  parameter logic [7:0]  SYNC0     = 8'h5A,
  parameter logic [7:0]  SYNC1     = 8'hA5,
  parameter int          TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  input  logic       iRequest,
  output logic [7:0] oWrData,
  output logic [7:0] oWrAddr,
  output logic       oWrEn,
  output logic       oDone,
  output logic       oErr,
  output logic [7:0] oErrCnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT0   = 3'd1,
    HUNT1   = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } CollectState;

  localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT - 1);

  CollectState state;
  logic [15:0] toCnt;
  logic [7:0]  curIdx;

  // oWrAddr advances the cycle after a write pulse, so the index for the byte
  // arriving now must account for an increment that is still pending.
  assign curIdx = oWrEn ? oWrAddr + 8'd1 : oWrAddr;

  // Single-process FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      oWrData <= 8'h00;
      oWrAddr <= 8'h00;
      oWrEn   <= 1'b0;
      oDone   <= 1'b0;
      oErr    <= 1'b0;
      oErrCnt <= 8'h00;
      toCnt   <= 16'h0000;
    end else begin
      oWrEn <= 1'b0;
      oErr  <= 1'b0;
      case (state)
        IDLE: begin
          toCnt <= 16'h0000;
          if (iRequest) state <= HUNT0;
        end
        HUNT0: begin
          toCnt <= 16'h0000;
          if (iRequest) begin
            oWrAddr <= 8'h00;
          end else if (iRxValid && iRxData == SYNC0) begin
            state <= HUNT1;
          end
        end
        HUNT1: begin
          if (iRequest) begin
            state   <= HUNT0;
            oWrAddr <= 8'h00;
            toCnt   <= 16'h0000;
          end else if (iRxValid) begin
            toCnt <= 16'h0000;
            if (iRxData == SYNC1) begin
              state   <= COLLECT;
              oWrAddr <= 8'h00;
            end else if (iRxData != SYNC0) begin
              state <= HUNT0;
            end
          end else if (toCnt == TO_LIMIT) begin
            state   <= HUNT0;
            oErr    <= 1'b1;
            oWrAddr <= 8'h00;
            toCnt   <= 16'h0000;
            if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;
          end else begin
            toCnt <= toCnt + 16'd1;
          end
        end
        COLLECT: begin
          // A request beats a same-cycle byte; a byte beats a same-cycle timeout.
          if (iRequest) begin
            state   <= HUNT0;
            oWrAddr <= 8'h00;
            toCnt   <= 16'h0000;
          end else if (iRxValid) begin
            toCnt   <= 16'h0000;
            oWrEn   <= 1'b1;
            oWrData <= iRxData;
            oWrAddr <= curIdx;
            if (curIdx == LAST_IDX) state <= DONE;
          end else if (toCnt == TO_LIMIT) begin
            state   <= HUNT0;
            oErr    <= 1'b1;
            oWrAddr <= 8'h00;
            toCnt   <= 16'h0000;
            if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;
          end else begin
            toCnt   <= toCnt + 16'd1;
            oWrAddr <= curIdx;
          end
        end
        DONE: begin
          toCnt <= 16'h0000;
          if (iRequest) begin
            state   <= HUNT0;
            oDone   <= 1'b0;
            oWrAddr <= 8'h00;
          end else begin
            oDone <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          toCnt <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcm_collect.sv
// Directed bench for mcm_collect: table of single-cycle vectors plus hand-written
// sequences for full frames, DONE handling, timeouts and reset.
module tb_mcm_collect;

  localparam int FRAME_LEN = 144;
  localparam int TIMEOUT   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] iRxData = 8'h00;
  logic       iRxValid = 1'b0;
  logic       iRequest = 1'b0;
  logic [7:0] oWrData;
  logic [7:0] oWrAddr;
  logic       oWrEn;
  logic       oDone;
  logic       oErr;
  logic [7:0] oErrCnt;

  int checks = 0;
  int errors = 0;

  mcm_collect #(
    .FRAME_LEN(FRAME_LEN),
    .SYNC0    (8'h5A),
    .SYNC1    (8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .iRxData (iRxData),
    .iRxValid(iRxValid),
    .iRequest(iRequest),
    .oWrData (oWrData),
    .oWrAddr (oWrAddr),
    .oWrEn   (oWrEn),
    .oDone   (oDone),
    .oErr    (oErr),
    .oErrCnt (oErrCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       valid;
    logic [7:0] data;
    logic       wrEn;
    logic [7:0] addr;
    logic [7:0] wrData;
    logic       done;
  } Vec;

  Vec vecs[21];

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic req, input logic valid, input logic [7:0] data);
    iRequest = req;
    iRxValid = valid;
    iRxData  = data;
    @(posedge clk);
    #1;
    iRequest = 1'b0;
    iRxValid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int errPulses;
    int firstErrAt;

    vecs[0]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h00, 8'h11, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h11, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h00, 8'h22, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h33, 1'b1, 8'h01, 8'h33, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 8'h33, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h33, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h33, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h33, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 8'h66, 1'b1, 8'h00, 8'h66, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h66, 1'b0};

    // Reset state, then release and confirm nothing moves.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutputs", {oWrEn, oWrAddr, oWrData, oDone, oErr, oErrCnt}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("afterRelease", {oWrEn, oWrAddr, oWrData, oDone, oErr, oErrCnt}, 32'h0);

    // Table vectors: sync hunting, first writes, request priority.
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].req, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d", i),
                  {oWrEn, oWrAddr, oWrData, oDone, oErr},
                  {vecs[i].wrEn, vecs[i].addr, vecs[i].wrData, vecs[i].done, 1'b0});
    end

    // Full frame at full rate: data equals address.
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i));
      checkOutput($sformatf("frameWrite%0d", i), {oWrEn, oWrAddr, oWrData, oDone},
                  {1'b1, 8'(i), 8'(i), 1'b0});
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("doneRise", {oWrEn, oDone, oWrAddr}, {1'b0, 1'b1, 8'(FRAME_LEN - 1)});

    // DONE ignores bytes; request wins over a same-cycle byte.
    applyStimulus(1'b0, 1'b1, 8'h99);
    checkOutput("doneIgnore1", {oWrEn, oDone}, {1'b0, 1'b1});
    applyStimulus(1'b0, 1'b1, 8'h5A);
    checkOutput("doneIgnore2", {oWrEn, oDone}, {1'b0, 1'b1});
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("doneRequest", {oWrEn, oDone, oWrAddr}, {1'b0, 1'b0, 8'h00});
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkOutput("rehuntNoWrite", oWrEn, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h07);
    checkOutput("rehuntWrite", {oWrEn, oWrAddr, oWrData}, {1'b1, 8'h00, 8'h07});

    // Inter-byte timeout after 10 bytes.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i));
    errPulses = 0;
    firstErrAt = -1;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (oErr) begin
        errPulses++;
        if (firstErrAt < 0) firstErrAt = k;
      end
    end
    checkOutput("timeoutPulses", errPulses, 1);
    checkOutput("timeoutLatency", firstErrAt, TIMEOUT);
    checkOutput("timeoutCount", oErrCnt, 8'd1);
    checkOutput("timeoutAddr", oWrAddr, 8'h00);

    // Byte landing on the would-be timeout cycle wins and restarts at address 0.
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    errPulses = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (oErr) errPulses++;
    end
    applyStimulus(1'b0, 1'b1, 8'h77);
    if (oErr) errPulses++;
    checkOutput("byteBeatsTimeout", {oWrEn, oWrAddr, oWrData}, {1'b1, 8'h00, 8'h77});
    checkOutput("noErrOnRace", errPulses, 0);
    checkOutput("errCntHeld", oErrCnt, 8'd1);

    // Asynchronous reset mid-frame.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    iRxValid = 1'b1;
    iRxData  = 8'h46;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncReset", {oWrEn, oWrAddr, oWrData, oDone, oErr, oErrCnt}, 32'h0);
    iRxValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    checkOutput("idleAfterReset", {oWrEn, oWrAddr, oWrData, oErrCnt}, 25'h0);

    // 256 forced timeouts from HUNT1: counter saturates at 255.
    applyStimulus(1'b1, 1'b0, 8'h00);
    errPulses = 0;
    for (int n = 0; n < 256; n++) begin
      applyStimulus(1'b0, 1'b1, 8'h5A);
      for (int k = 0; k < TIMEOUT + 2; k++) begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        if (oErr) errPulses++;
      end
      if (n == 9) checkOutput("errCntTen", oErrCnt, 8'd10);
      if (n == 254) checkOutput("errCnt255", oErrCnt, 8'd255);
    end
    checkOutput("errPulses256", errPulses, 256);
    checkOutput("errCntSaturated", oErrCnt, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcm_collect.md
MCM_COLLECT -- requirements
Module: mcm_collect

Interface
REQ-001 Parameter FRAME_LEN, default 144, SHALL be the payload bytes per frame (range 1..256); 144 = 3 streams x 16 iterations x 3 bytes.
REQ-002 Parameter SYNC0, default 8'h5A, SHALL be the first frame marker byte.
REQ-003 Parameter SYNC1, default 8'hA5, SHALL be the second frame marker byte.
REQ-004 Parameter TIMEOUT, default 50000, SHALL be the maximum number of clk cycles allowed between bytes inside a frame (16-bit counter).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 iRxData  input  8  received byte, valid only when iRxValid=1.
REQ-008 iRxValid  input  1  one-cycle strobe per received byte.
REQ-009 iRequest  input  1  one-cycle pulse from coordinator: discard current frame, start collecting a new one.
REQ-010 oWrData  output  8  byte to MCM RAM write port.
REQ-011 oWrAddr  output  8  MCM RAM write address.
REQ-012 oWrEn  output  1  MCM RAM write enable, one-cycle pulse per byte.
REQ-013 oDone  output  1  level: full frame stored in RAM; feeds packer start input.
REQ-014 oErr  output  1  one-cycle pulse on inter-byte timeout inside a frame.
REQ-015 oErrCnt  output  8  saturating count of timeout events.

Function
REQ-016 States SHALL be IDLE, HUNT0, HUNT1, COLLECT, DONE (3-bit encoding).
REQ-017 IDLE: all outputs held at reset values; iRequest -> HUNT0; iRxValid ignored.
REQ-018 HUNT0: iRxValid with iRxData==SYNC0 -> HUNT1; any other byte stays HUNT0; no timeout in HUNT0.
REQ-019 HUNT1: iRxValid with iRxData==SYNC1 -> COLLECT with oWrAddr=0; byte==SYNC0 stays HUNT1; any other byte -> HUNT0.
REQ-020 COLLECT: each iRxValid SHALL cause, on the next cycle, oWrEn=1, oWrData=iRxData, oWrAddr=current byte index (1-cycle latency, registered).
REQ-021 oWrAddr SHALL increment by 1 in the cycle after each oWrEn pulse; it SHALL never wrap inside a frame.
REQ-022 When the write of byte index FRAME_LEN-1 is issued, state SHALL go DONE and oDone SHALL rise in the cycle after that oWrEn pulse.
REQ-023 DONE: oDone held 1, oWrEn 0, iRxValid ignored; iRequest -> HUNT0 with oDone cleared on the next cycle and oWrAddr reset to 0.
REQ-024 Timeout counter SHALL clear on every iRxValid and on COLLECT entry, and count only in HUNT1 and COLLECT.
REQ-025 Counter reaching TIMEOUT in HUNT1 or COLLECT SHALL: pulse oErr for one cycle, increment oErrCnt (saturating at 255), reset oWrAddr to 0, go HUNT0; bytes already written are not erased.
REQ-026 iRequest in HUNT0/HUNT1/COLLECT SHALL restart at HUNT0 with oWrAddr=0 and timeout counter cleared, no oErr.
REQ-027 iRequest and iRxValid in the same cycle: iRequest SHALL win and the byte SHALL be discarded (no oWrEn).
REQ-028 Timeout and iRxValid in the same cycle: the byte SHALL win (counter clears, no oErr).
REQ-029 oWrEn SHALL never be asserted outside COLLECT or on the cycle following it with a non-COLLECT cause.
REQ-030 iRxValid on consecutive cycles SHALL be accepted at full rate (one write per clk).

Reset
REQ-031 reset low SHALL asynchronously force: state=IDLE, oWrData=0, oWrAddr=0, oWrEn=0, oDone=0, oErr=0, oErrCnt=0, timeout counter=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the block stays in IDLE until iRequest.
REQ-033 Reset release SHALL be synchronous to clk in effect (no output changes until the first rising edge after release).

Verification
REQ-034 iRequest, then bytes 5A A5 00..8F (FRAME_LEN=144) -> 144 oWrEn pulses, oWrAddr 0..143, oWrData==addr, oDone=1 one cycle after last write.
REQ-035 iRequest, bytes 5A 5A A5 11 -> HUNT1 held across repeated SYNC0, first write addr 0 data 11; bytes 5A 00 5A A5 -> COLLECT entered only after the final A5.
REQ-036 In COLLECT after 10 bytes, no iRxValid for TIMEOUT cycles -> single oErr pulse, oErrCnt=1, state HUNT0, next 5A A5 restarts at addr 0.
REQ-037 In DONE, iRxValid bytes -> no oWrEn; iRequest asserted same cycle as iRxValid -> no write, oDone=0 next cycle, state HUNT0.
REQ-038 Reset pulsed at byte 70 -> all outputs zero immediately; stays IDLE after release; 256 forced timeouts -> oErrCnt saturates at 255.
